fpu_op_sequencer: RTL and testbench

Command-side initiator for the floating-point ALU dispatcher (add/sub/mul/div/sqrt, 4-bit op select). Accepts tagged commands over a valid/ready interface and drives operands and op select to the ALU. It waits a fixed settle window, captures the ALU result and flags, and returns a tagged response over a second valid/ready interface. Sits between the core's issue logic and the combinational ALU. Between operations the ALU op select is parked at 0, so no ALU path is enabled.

---
 rtl/fpu_op_sequencer_pkg.sv | 23 ++
 rtl/fpu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_sequencer_pkg.sv
// Shared definitions for the FPU op sequencer: ALU op codes, the
// legal-op check and the sequencer state encoding.
package fpu_op_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_SQRT = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Only add/sub/mul/div/sqrt select an ALU path; everything else is refused.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SQRT);
    endfunction

endpackage

// File: rtl/fpu_op_sequencer.sv
// Command-side initiator for the floating-point ALU: accepts one tagged
// command, holds the ALU inputs for a settle window, captures the result
// and flags, and returns them as a tagged response.
module fpu_op_sequencer
    import fpu_op_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a_operand,
    output logic [31:0]      alu_b_operand,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_exception,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
);

    // Counter reload: the capture happens on the cycle the counter reads 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_e       state_r;
    logic [3:0]       cnt_r;
    logic [3:0]       alu_op_r;
    logic [31:0]      alu_a_r;
    logic [31:0]      alu_b_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_result_r;
    logic             rsp_exception_r;
    logic             rsp_overflow_r;
    logic             rsp_underflow_r;
    logic             rsp_illegal_r;
    logic [TAG_W-1:0] rsp_tag_r;

    // Ready depends on state only, so reset makes it visible immediately.
    assign cmd_ready = (state_r == ST_IDLE);

    assign alu_op        = alu_op_r;
    assign alu_a_operand = alu_a_r;
    assign alu_b_operand = alu_b_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_result    = rsp_result_r;
    assign rsp_exception = rsp_exception_r;
    assign rsp_overflow  = rsp_overflow_r;
    assign rsp_underflow = rsp_underflow_r;
    assign rsp_illegal   = rsp_illegal_r;
    assign rsp_tag       = rsp_tag_r;

    // Sequencer FSM with settle counter, ALU drive and response capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 4'd0;
            alu_op_r        <= OP_NOP;
            alu_a_r         <= 32'd0;
            alu_b_r         <= 32'd0;
            rsp_valid_r     <= 1'b0;
            rsp_result_r    <= 32'd0;
            rsp_exception_r <= 1'b0;
            rsp_overflow_r  <= 1'b0;
            rsp_underflow_r <= 1'b0;
            rsp_illegal_r   <= 1'b0;
            rsp_tag_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rsp_tag_r <= cmd_tag;
                        if (is_legal_op(cmd_op)) begin
                            alu_op_r <= cmd_op;
                            alu_a_r  <= cmd_a;
                            alu_b_r  <= (cmd_op == OP_SQRT) ? 32'd0 : cmd_b;
                            cnt_r    <= SETTLE_LOAD;
                            state_r  <= ST_ISSUE;
                        end else begin
                            // Refused op: answer at once without ever driving the ALU.
                            rsp_result_r    <= 32'd0;
                            rsp_exception_r <= 1'b0;
                            rsp_overflow_r  <= 1'b0;
                            rsp_underflow_r <= 1'b0;
                            rsp_illegal_r   <= 1'b1;
                            rsp_valid_r     <= 1'b1;
                            state_r         <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_r == 4'd0) begin
                        rsp_result_r    <= alu_result;
                        rsp_exception_r <= alu_exception;
                        rsp_overflow_r  <= alu_overflow;
                        rsp_underflow_r <= alu_underflow;
                        rsp_illegal_r   <= 1'b0;
                        rsp_valid_r     <= 1'b1;
                        // Park the ALU so no path stays enabled while the response waits.
                        alu_op_r        <= OP_NOP;
                        alu_a_r         <= 32'd0;
                        alu_b_r         <= 32'd0;
                        state_r         <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    alu_op_r    <= OP_NOP;
                    alu_a_r     <= 32'd0;
                    alu_b_r     <= 32'd0;
                    rsp_valid_r <= 1'b0;
                    cnt_r       <= 4'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: a behavioural single-precision
// ALU stands in for the real ALU, directed scenarios cover the main
// paths and a randomized loop checks against the reference rules.
module tb_fpu_op_sequencer;

    localparam int unsigned S     = 2;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [31:0]      result;
        logic             exc;
        logic             ovf;
        logic             unf;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_a_operand;
    logic [31:0]      alu_b_operand;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_exception;
    logic             alu_overflow;
    logic             alu_underflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_exception;
    logic             rsp_overflow;
    logic             rsp_underflow;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;

    int n_vec = 0;
    int n_err = 0;

    fpu_op_sequencer #(.SETTLE_CYCLES(S), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a_operand(alu_a_operand), .alu_b_operand(alu_b_operand), .alu_op(alu_op),
        .alu_result(alu_result), .alu_exception(alu_exception),
        .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exception(rsp_exception), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single precision to real (denormals flushed to zero).
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real to single precision (truncating); returns {ovf, unf, bits}.
    function automatic logic [33:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:0] == 63'd0)  return {2'b00, d[63], 31'd0};
        else if (e >= 255)     return {2'b10, d[63], 8'hFF, 23'd0};
        else if (e <= 0)       return {2'b01, d[63], 31'd0};
        else                   return {2'b00, d[63], 8'(e), d[51:29]};
    endfunction

    // Behavioural ALU: {exception, overflow, underflow, result}.
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        real         ra;
        real         rb;
        logic [33:0] c;
        ra = sp2r(a);
        rb = sp2r(b);
        case (op)
            4'd1: begin c = r2sp(ra + rb); return {3'b000, c[31:0]}; end
            4'd2: begin c = r2sp(ra - rb); return {3'b000, c[31:0]}; end
            4'd3: begin c = r2sp(ra * rb); return {1'b0, c[33:32], c[31:0]}; end
            4'd4: begin
                if (rb == 0.0) return {3'b100, 32'd0};
                c = r2sp(ra / rb); return {3'b000, c[31:0]};
            end
            4'd5: begin
                if (ra < 0.0) return {3'b100, 32'd0};
                c = r2sp($sqrt(ra)); return {3'b000, c[31:0]};
            end
            default: return 35'd0;
        endcase
    endfunction

    always_comb begin
        {alu_exception, alu_overflow, alu_underflow, alu_result} = alu_fn(alu_op, alu_a_operand, alu_b_operand);
    end

    function automatic rsp_t snap();
        return '{rsp_result, rsp_exception, rsp_overflow, rsp_underflow, rsp_illegal, rsp_tag};
    endfunction

    // Drives one command through accept, settle, hold and handshake, and reports what it saw.
    // lat = edges from the accept edge until rsp_valid is seen (-1 timeout, -2 never accepted).
    task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag, input int hold,
                            output int lat, output rsp_t rsp,
                            output logic [3:0] iss_op, output logic [31:0] iss_a, output logic [31:0] iss_b,
                            output bit iss_unstable, output bit alu_leak, output bit rsp_unstable,
                            output bit ready_busy, output logic ready_after, output logic valid_after);
        bit got;
        bit first;
        got = 1'b0; first = 1'b1;
        iss_op = 4'd0; iss_a = 32'd0; iss_b = 32'd0;
        iss_unstable = 1'b0; alu_leak = 1'b0; rsp_unstable = 1'b0; ready_busy = 1'b0;
        ready_after = 1'bx; valid_after = 1'bx; rsp = '0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clk); #1; got = 1'b1; break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_tag = TAG_W'($urandom);
        if (!got) begin lat = -2; return; end
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready !== 1'b0) ready_busy = 1'b1;
            if (rsp_valid === 1'b1) begin lat = i; break; end
            if (first) begin
                iss_op = alu_op; iss_a = alu_a_operand; iss_b = alu_b_operand; first = 1'b0;
            end else if (alu_op !== iss_op || alu_a_operand !== iss_a || alu_b_operand !== iss_b) begin
                iss_unstable = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) return;
        rsp = snap();
        for (int i = 0; i <= hold; i++) begin
            if (snap() !== rsp || rsp_valid !== 1'b1) rsp_unstable = 1'b1;
            if (alu_op !== 4'd0) alu_leak = 1'b1;
            if (cmd_ready !== 1'b0) ready_busy = 1'b1;
            if (i < hold) begin @(posedge clk); #1; end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ready_after = cmd_ready;
        valid_after = rsp_valid;
    endtask

    task automatic test_reset();
        n_vec++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        n_vec++;
        if ({rsp_valid, alu_op, alu_a_operand, alu_b_operand} !== 69'd0) begin
            n_err++; $display("FAIL reset_alu_valid got=%b/%h/%h/%h want=0", rsp_valid, alu_op, alu_a_operand, alu_b_operand);
        end
        n_vec++;
        if (snap() !== rsp_t'(0)) begin n_err++; $display("FAIL reset_rsp got=%h want=0", snap()); end
    endtask

    task automatic test_add();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        send_cmd(4'd1, 32'h3F800000, 32'h40000000, 4'd3, 0, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (lat != int'(S)) begin n_err++; $display("FAIL add_latency got=%0d want=%0d", lat, S); end
        n_vec++;
        if (r !== rsp_t'{32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3}) begin
            n_err++; $display("FAIL add_rsp got=%h want=%h", r, rsp_t'{32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3});
        end
        n_vec++;
        if ({o, ia, ib, u} !== {4'd1, 32'h3F800000, 32'h40000000, 1'b0}) begin
            n_err++; $display("FAIL add_issue got=%h/%h/%h unstable=%b want=1/3f800000/40000000/0", o, ia, ib, u);
        end
    endtask

    task automatic test_mul();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        send_cmd(4'd3, 32'h40000000, 32'h40400000, 4'd5, 1, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (r !== rsp_t'{32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5} || lat != int'(S)) begin
            n_err++; $display("FAIL mul_rsp got=%h lat=%0d want=%h lat=%0d", r, lat, rsp_t'{32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5}, S);
        end
        send_cmd(4'd3, 32'h7F000000, 32'h7F000000, 4'd6, 0, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (r !== rsp_t'{32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6}) begin
            n_err++; $display("FAIL mul_overflow got=%h want=%h", r, rsp_t'{32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6});
        end
    endtask

    task automatic test_sqrt();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        send_cmd(4'd5, 32'h40800000, 32'hDEADBEEF, 4'd12, 0, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if ({o, ib, u} !== {4'd5, 32'd0, 1'b0}) begin
            n_err++; $display("FAIL sqrt_b_forced got op=%h b=%h unstable=%b want op=5 b=0", o, ib, u);
        end
        n_vec++;
        if (r !== rsp_t'{32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12}) begin
            n_err++; $display("FAIL sqrt_rsp got=%h want=%h", r, rsp_t'{32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12});
        end
    endtask

    task automatic test_illegal();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        send_cmd(4'd7, 32'h3F800000, 32'h3F800000, 4'd9, 2, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (lat != 0) begin n_err++; $display("FAIL illegal_latency got=%0d want=0", lat); end
        n_vec++;
        if (r !== rsp_t'{32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9}) begin
            n_err++; $display("FAIL illegal_rsp got=%h want=%h", r, rsp_t'{32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9});
        end
        n_vec++;
        if (lk !== 1'b0) begin n_err++; $display("FAIL illegal_alu_driven got=%b want=0", lk); end
    endtask

    task automatic test_back_to_back();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        send_cmd(4'd4, 32'h40C00000, 32'h40000000, 4'd1, 5, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if ({ru, rb, lk} !== 3'b000) begin
            n_err++; $display("FAIL bp_hold got unstable=%b ready_busy=%b alu_leak=%b want=000", ru, rb, lk);
        end
        n_vec++;
        if (r !== rsp_t'{32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL bp_rsp got=%h want=%h", r, rsp_t'{32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1});
        end
        n_vec++;
        if ({ra, va} !== 2'b10) begin
            n_err++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", ra, va);
        end
        send_cmd(4'd2, 32'h40400000, 32'h3F800000, 4'd2, 0, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (r !== rsp_t'{32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2} || lat != int'(S)) begin
            n_err++; $display("FAIL b2b_sub got=%h lat=%0d want=%h lat=%0d", r, lat, rsp_t'{32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2}, S);
        end
    endtask

    task automatic test_reset_mid_issue();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        bit seen;
        seen = 1'b0;
        cmd_op = 4'd3; cmd_a = 32'h40000000; cmd_b = 32'h40000000; cmd_tag = 4'd14; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({alu_op, cmd_ready, rsp_valid} !== {4'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL rst_async got op=%h ready=%b valid=%b want op=0 ready=1 valid=0", alu_op, cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL rst_aborted_rsp got=1 want=0"); end
        send_cmd(4'd1, 32'h40000000, 32'h40000000, 4'd15, 0, lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
        n_vec++;
        if (r !== rsp_t'{32'h40800000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15} || lat != int'(S)) begin
            n_err++; $display("FAIL rst_next_cmd got=%h lat=%0d want=%h lat=%0d", r, lat, rsp_t'{32'h40800000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15}, S);
        end
    endtask

    task automatic test_random();
        int lat; rsp_t r; logic [3:0] o; logic [31:0] ia, ib; bit u, lk, ru, rb; logic ra, va;
        logic [3:0] op; logic [31:0] a, b, b_eff; logic [TAG_W-1:0] tag;
        logic [34:0] ref_alu; bit legal; rsp_t exp_r;
        for (int n = 0; n < 60; n++) begin
            op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 5));
            a   = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
            b   = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
            tag = TAG_W'($urandom);
            legal = (op >= 4'd1 && op <= 4'd5);
            b_eff = (op == 4'd5) ? 32'd0 : b;
            ref_alu = legal ? alu_fn(op, a, b_eff) : 35'd0;
            exp_r = '{ref_alu[31:0], ref_alu[34], ref_alu[33], ref_alu[32], !legal, tag};
            send_cmd(op, a, b, tag, $urandom_range(0, 3), lat, r, o, ia, ib, u, lk, ru, rb, ra, va);
            n_vec++;
            if (lat != (legal ? int'(S) : 0) || r !== exp_r) begin
                n_err++; $display("FAIL rand_rsp[%0d] op=%h got=%h lat=%0d want=%h lat=%0d", n, op, r, lat, exp_r, legal ? S : 0);
            end
            n_vec++;
            if ({o, ia, ib} !== (legal ? {op, a, b_eff} : 68'd0) || u || lk || ru || rb || {ra, va} !== 2'b10) begin
                n_err++; $display("FAIL rand_seq[%0d] got issue=%h/%h/%h flags=%b%b%b%b ready=%b valid=%b want issue=%h/%h/%h flags=0000 ready=1 valid=0",
                                  n, o, ia, ib, u, lk, ru, rb, ra, va, legal ? op : 4'd0, legal ? a : 32'd0, legal ? b_eff : 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_add();
        test_mul();
        test_sqrt();
        test_illegal();
        test_back_to_back();
        test_reset_mid_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
